uart_rx_fifo: RTL and testbench

Receive-side byte buffer for the UART peripheral, placed directly downstream of the RS-232 receiver control FSM. It captures each completed 8-bit frame on the receiver's one-cycle "save data" pulse and holds it in a circular FIFO until the processor bus interface pops it. It reports occupancy, full/empty and a sticky overrun flag, and drives a level interrupt request toward the core.

---
 rtl/uart_rx_fifo.sv | 81 ++++++++
 tb/tb_uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer for the UART peripheral.
// Captures each completed frame on the receiver's save-data pulse and holds it in a
// circular FIFO until the bus pops it. Reports occupancy, full/empty, a sticky overrun
// flag and a level interrupt request.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  clr_overrun_i,
    input  logic                  irq_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  overrun_o,
    output logic                  rx_irq_o
);

    localparam int              ADDR_W  = CNT_W - 1;
    localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

    // Pointers carry one extra wrap bit above the array index so that full and
    // empty are distinguishable when the index bits match.
    logic [CNT_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic push_ok;
    logic pop_ok;
    logic drop;

    // Occupancy flags derived purely from the registered pointers.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);
    assign count_o = wr_ptr - rd_ptr;

    // A pop on a full FIFO frees the head slot in the same cycle, so a coincident
    // push is still accepted. A pop on an empty FIFO is ignored.
    assign pop_ok  = rd_en_i & ~empty_o;
    assign push_ok = wr_en_i & (~full_o | rd_en_i);
    assign drop    = wr_en_i & full_o & ~rd_en_i;

    // First-word-fall-through head, forced to zero when nothing is stored.
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // Level interrupt: data waiting or an unacknowledged overrun.
    assign rx_irq_o = irq_en_i & (~empty_o | overrun_o);

    // Pointer and overrun state; set of overrun takes priority over its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // pre-edge values, so the order of these statements does not matter.
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            if (drop)
                overrun_o <= 1'b1;
            else if (clr_overrun_i)
                overrun_o <= 1'b0;
        end
    end

    // Storage array write on an accepted push.
    // NOTE: the array has no reset; stale contents are never visible because the
    // pointers are reset and rd_data_o is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_data_i;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH=8, 8-bit data).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       rd_en_i;
    logic       clr_overrun_i;
    logic       irq_en_i;
    logic [7:0] rd_data_o;
    logic       empty_o;
    logic       full_o;
    logic [3:0] count_o;
    logic       overrun_o;
    logic       rx_irq_o;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .rd_en_i       (rd_en_i),
        .clr_overrun_i (clr_overrun_i),
        .irq_en_i      (irq_en_i),
        .rd_data_o     (rd_data_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .count_o       (count_o),
        .overrun_o     (overrun_o),
        .rx_irq_o      (rx_irq_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit later so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
        wr_en_i       = 1'b0;
        rd_en_i       = 1'b0;
        clr_overrun_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        tick();
    endtask

    task automatic pop();
        rd_en_i = 1'b1;
        tick();
    endtask

    task automatic push_pop(input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        rd_en_i   = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", rd_data_o); end
        checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", rx_irq_o); end
    endtask

    task automatic test_ordering();
        push(8'h55);
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL ord_cnt1: got %0d want 1", count_o); end
        checks++; if (rd_data_o !== 8'h55) begin errors++; $display("FAIL ord_head1: got %h want 55", rd_data_o); end
        checks++; if (rx_irq_o !== 1'b1) begin errors++; $display("FAIL ord_irq1: got %b want 1", rx_irq_o); end
        push(8'hA3);
        checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL ord_cnt2: got %0d want 2", count_o); end
        checks++; if (rd_data_o !== 8'h55) begin errors++; $display("FAIL ord_head2: got %h want 55", rd_data_o); end
        pop();
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL ord_cnt3: got %0d want 1", count_o); end
        checks++; if (rd_data_o !== 8'hA3) begin errors++; $display("FAIL ord_head3: got %h want a3", rd_data_o); end
        checks++; if (rx_irq_o !== 1'b1) begin errors++; $display("FAIL ord_irq3: got %b want 1", rx_irq_o); end
        pop();
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL ord_cnt4: got %0d want 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ord_empty: got %b want 1", empty_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL ord_data0: got %h want 00", rd_data_o); end
        checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL ord_irq4: got %b want 0", rx_irq_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push(8'(i));
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full_o); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL ovf_cnt8: got %0d want 8", count_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", overrun_o); end
        push(8'hFF);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overrun_o); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL ovf_cnt_keep: got %0d want 8", count_o); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rd_data_o !== 8'(i)) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, rd_data_o, 8'(i)); end
            pop();
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b want 1", empty_o); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overrun_o); end
        checks++; if (rx_irq_o !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b want 1", rx_irq_o); end
        clr_overrun_i = 1'b1;
        tick();
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overrun_o); end
        checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL ovf_irq_clr: got %b want 0", rx_irq_o); end
    endtask

    // Push every cycle, pop from the fourth cycle on; pointers start at 8 so they wrap.
    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int i = 0; i < 20; i++) begin
            if (i >= 3) begin
                exp = q.pop_front();
                checks++; if (rd_data_o !== exp) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", i, rd_data_o, exp); end
                q.push_back(8'(8'h10 + i));
                push_pop(8'(8'h10 + i));
            end else begin
                q.push_back(8'(8'h10 + i));
                push(8'(8'h10 + i));
            end
            checks++; if (count_o !== 4'(q.size()) || count_o > 4'd8) begin errors++; $display("FAIL wrap_cnt%0d: got %0d want %0d", i, count_o, q.size()); end
        end
        while (q.size() > 0) begin
            exp = q.pop_front();
            checks++; if (rd_data_o !== exp) begin errors++; $display("FAIL wrap_drain: got %h want %h", rd_data_o, exp); end
            pop();
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 8; i++) push(8'(8'hE0 + i));
        push_pop(8'hEE);
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL sf_cnt: got %0d want 8", count_o); end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL sf_full: got %b want 1", full_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL sf_ovr: got %b want 0", overrun_o); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (rd_data_o !== 8'(8'hE0 + i)) begin errors++; $display("FAIL sf_data%0d: got %h want %h", i, rd_data_o, 8'(8'hE0 + i)); end
            pop();
        end
        checks++; if (rd_data_o !== 8'hEE) begin errors++; $display("FAIL sf_last: got %h want ee", rd_data_o); end
        pop();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL sf_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_simul_empty();
        push_pop(8'h3C);
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL se_cnt: got %0d want 1", count_o); end
        checks++; if (rd_data_o !== 8'h3C) begin errors++; $display("FAIL se_data: got %h want 3c", rd_data_o); end
        pop();
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL se_cnt0: got %0d want 0", count_o); end
    endtask

    task automatic test_underflow();
        pop();
        pop();
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL uf_cnt: got %0d want 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL uf_empty: got %b want 1", empty_o); end
        push(8'h9A);
        checks++; if (rd_data_o !== 8'h9A || count_o !== 4'd1) begin errors++; $display("FAIL uf_after: got %h/%0d want 9a/1", rd_data_o, count_o); end
        pop();
    endtask

    task automatic test_clr_conflict();
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        wr_en_i       = 1'b1;
        wr_data_i     = 8'hBB;
        clr_overrun_i = 1'b1;
        tick();
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL cc_set_wins: got %b want 1", overrun_o); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL cc_cnt: got %0d want 8", count_o); end
        irq_en_i = 1'b0;
        #1;
        checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL cc_irq_dis: got %b want 0", rx_irq_o); end
        irq_en_i = 1'b1;
        clr_overrun_i = 1'b1;
        tick();
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL cc_clr: got %b want 0", overrun_o); end
        checks++; if (rd_data_o !== 8'h40) begin errors++; $display("FAIL cc_head: got %h want 40", rd_data_o); end
    endtask

    // Leaves 8 entries from test_clr_conflict, then adds nothing: reset with data stored.
    task automatic test_reset_midrun();
        for (int i = 0; i < 5; i++) pop();
        checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL rm_pre: got %0d want 3", count_o); end
        #2;
        rst_n = 1'b0;
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        checks++; if (empty_o !== 1'b1 || count_o !== 4'd0) begin errors++; $display("FAIL rm_post: got %b/%0d want 1/0", empty_o, count_o); end
    endtask

    initial begin
        rst_n         = 1'b0;
        wr_en_i       = 1'b0;
        wr_data_i     = 8'h00;
        rd_en_i       = 1'b0;
        clr_overrun_i = 1'b0;
        irq_en_i      = 1'b1;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_ordering();
        test_overflow();
        test_wrap();
        test_simul_full();
        test_simul_empty();
        test_underflow();
        test_clr_conflict();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
